// File: rtl/as_hdr_parser_if.sv
// Packet-bus monitor and LUT handshake bundle for the anti-spoof header parser.
interface as_hdr_parser_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = 8,
  parameter int NUM_IQ_BITS = 3
);
  logic [DATA_WIDTH-1:0]  in_data;
  logic [CTRL_WIDTH-1:0]  in_ctrl;
  logic                   in_wr;
  logic [47:0]            dst_mac;
  logic [47:0]            src_mac;
  logic [31:0]            dst_ip;
  logic [31:0]            src_ip;
  logic [NUM_IQ_BITS-1:0] src_port;
  logic                   is_ip;
  logic                   lookup_req;
  logic                   lookup_ack;
  logic                   parse_done;
  logic                   runt_pkt;
  logic                   hdr_overflow;

  // Environment side: drives the packet bus and the LUT acknowledge.
  modport master (
    output in_data, in_ctrl, in_wr, lookup_ack,
    input  dst_mac, src_mac, dst_ip, src_ip, src_port, is_ip,
           lookup_req, parse_done, runt_pkt, hdr_overflow
  );

  // Parser side: monitors the bus and presents extracted headers.
  modport slave (
    input  in_data, in_ctrl, in_wr, lookup_ack,
    output dst_mac, src_mac, dst_ip, src_ip, src_port, is_ip,
           lookup_req, parse_done, runt_pkt, hdr_overflow
  );
endinterface

// File: rtl/as_hdr_parser.sv
// Passive header sniffer: pulls port/MAC/IPv4 fields out of each packet,
// queues them in a 2-entry FIFO and hands them to the MAC CAM LUT.
module as_hdr_parser #(
  parameter int                   DATA_WIDTH         = 64,
  parameter int                   CTRL_WIDTH         = 8,
  parameter int                   NUM_IQ_BITS        = 3,
  parameter int                   SRC_PORT_POS       = 16,
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = 8'hFF
) (
  input logic           clk,
  input logic           reset,
  as_hdr_parser_if.slave bus
);

  typedef enum logic [2:0] {
    P_IDLE, P_HDRS, P_DW2, P_DW3, P_DW4, P_DW5, P_WAIT_EOP
  } parseState_t;

  typedef enum logic [1:0] {
    REQ_IDLE, REQ_WAIT, ACK_LOW
  } reqState_t;

  typedef struct packed {
    logic                   isIp;
    logic [NUM_IQ_BITS-1:0] srcPort;
    logic [47:0]            dstMac;
    logic [47:0]            srcMac;
    logic [31:0]            srcIp;
    logic [31:0]            dstIp;
  } hdrEntry_t;

  parseState_t parseState_q, parseState_d;
  reqState_t   reqState_q, reqState_d;

  logic [DATA_WIDTH-1:0] inData;
  logic                  ctrlZero;

  logic capPort, capW1, capW2, capW4, pushReq, runt;
  logic lookupReq, pop, fifoPush, overflow;

  logic [NUM_IQ_BITS-1:0] srcPort_q;
  logic [47:0]            dstMac_q;
  logic [15:0]            srcMacHi_q;
  logic [31:0]            srcMacLo_q;
  logic [15:0]            ethertype_q;
  logic [31:0]            srcIp_q;
  logic [15:0]            dstIpHi_q;

  hdrEntry_t   mem_q [2];
  hdrEntry_t   newEntry, head;
  logic        wrPtr_q, rdPtr_q;
  logic [1:0]  count_q, count_d;
  logic        parseDone_q, overflow_q, runt_q;
  logic        newIsIp;

  assign inData   = bus.in_data;
  assign ctrlZero = (bus.in_ctrl == '0);

  // Parser state register; reset drops back to IDLE so a cut packet is skipped.
  always_ff @(posedge clk) begin
    if (reset) parseState_q <= P_IDLE;
    else       parseState_q <= parseState_d;
  end

  // Parser next state: walk the first five data words, bail out on early EOP.
  always_comb begin
    parseState_d = parseState_q;
    if (bus.in_wr) begin
      case (parseState_q)
        P_IDLE:     if (bus.in_ctrl == IO_QUEUE_STAGE_NUM) parseState_d = P_HDRS;
        P_HDRS:     if (ctrlZero) parseState_d = P_DW2;
        P_DW2:      parseState_d = ctrlZero ? P_DW3 : P_IDLE;
        P_DW3:      parseState_d = ctrlZero ? P_DW4 : P_IDLE;
        P_DW4:      parseState_d = ctrlZero ? P_DW5 : P_IDLE;
        P_DW5:      parseState_d = ctrlZero ? P_WAIT_EOP : P_IDLE;
        P_WAIT_EOP: if (!ctrlZero) parseState_d = P_IDLE;
        default:    parseState_d = P_IDLE;
      endcase
    end
  end

  // Parser outputs: which field group to capture, when to push, when the packet is a runt.
  always_comb begin
    capPort = 1'b0;
    capW1   = 1'b0;
    capW2   = 1'b0;
    capW4   = 1'b0;
    pushReq = 1'b0;
    runt    = 1'b0;
    if (bus.in_wr) begin
      case (parseState_q)
        P_IDLE: capPort = (bus.in_ctrl == IO_QUEUE_STAGE_NUM);
        P_HDRS: capW1   = ctrlZero;
        P_DW2:  begin capW2 = ctrlZero; runt = !ctrlZero; end
        P_DW3:  runt = !ctrlZero;
        P_DW4:  begin capW4 = ctrlZero; runt = !ctrlZero; end
        P_DW5:  pushReq = 1'b1;
        default: ;
      endcase
    end
  end

  // Field capture registers, filled word by word as the header streams past.
  always_ff @(posedge clk) begin
    if (reset) begin
      srcPort_q   <= '0;
      dstMac_q    <= '0;
      srcMacHi_q  <= '0;
      srcMacLo_q  <= '0;
      ethertype_q <= '0;
      srcIp_q     <= '0;
      dstIpHi_q   <= '0;
    end else begin
      if (capPort) srcPort_q <= inData[SRC_PORT_POS +: NUM_IQ_BITS];
      if (capW1) begin
        dstMac_q   <= inData[63:16];
        srcMacHi_q <= inData[15:0];
      end
      if (capW2) begin
        srcMacLo_q  <= inData[63:32];
        ethertype_q <= inData[31:16];
      end
      if (capW4) begin
        srcIp_q   <= inData[47:16];
        dstIpHi_q <= inData[15:0];
      end
    end
  end

  // The last dst_ip half comes straight off word 5; IPs are zeroed for non-IPv4.
  assign newIsIp          = (ethertype_q == 16'h0800);
  assign newEntry.isIp    = newIsIp;
  assign newEntry.srcPort = srcPort_q;
  assign newEntry.dstMac  = dstMac_q;
  assign newEntry.srcMac  = {srcMacHi_q, srcMacLo_q};
  assign newEntry.srcIp   = newIsIp ? srcIp_q : 32'h0;
  assign newEntry.dstIp   = newIsIp ? {dstIpHi_q, inData[63:48]} : 32'h0;

  // A full FIFO still accepts a push when the head is being popped the same cycle.
  assign fifoPush = pushReq && ((count_q != 2'd2) || pop);
  assign overflow = pushReq && (count_q == 2'd2) && !pop;

  // Count next value from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({fifoPush, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; validity is tracked by the count, so the entries need no reset.
  always_ff @(posedge clk) begin
    if (fifoPush) mem_q[wrPtr_q] <= newEntry;
  end

  // FIFO pointers, occupancy and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      count_q     <= 2'd0;
      parseDone_q <= 1'b0;
      overflow_q  <= 1'b0;
      runt_q      <= 1'b0;
    end else begin
      if (fifoPush) wrPtr_q <= ~wrPtr_q;
      if (pop)      rdPtr_q <= ~rdPtr_q;
      count_q     <= count_d;
      parseDone_q <= fifoPush;
      overflow_q  <= overflow;
      runt_q      <= runt;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) reqState_q <= REQ_IDLE;
    else       reqState_q <= reqState_d;
  end

  // Handshake next state: a new request needs ack low first, so a lingering ack cannot complete it.
  always_comb begin
    reqState_d = reqState_q;
    case (reqState_q)
      REQ_IDLE: if ((count_q != 2'd0) && !bus.lookup_ack) reqState_d = REQ_WAIT;
      REQ_WAIT: if (bus.lookup_ack) reqState_d = ACK_LOW;
      ACK_LOW:  if (!bus.lookup_ack) reqState_d = REQ_IDLE;
      default:  reqState_d = REQ_IDLE;
    endcase
  end

  // Handshake outputs: request level and the pop strobe on a sampled ack.
  always_comb begin
    lookupReq = (reqState_q == REQ_WAIT);
    pop       = (reqState_q == REQ_WAIT) && bus.lookup_ack;
  end

  assign head = (count_q != 2'd0) ? mem_q[rdPtr_q] : '0;

  assign bus.dst_mac      = head.dstMac;
  assign bus.src_mac      = head.srcMac;
  assign bus.dst_ip       = head.dstIp;
  assign bus.src_ip       = head.srcIp;
  assign bus.src_port     = head.srcPort;
  assign bus.is_ip        = head.isIp;
  assign bus.lookup_req   = lookupReq;
  assign bus.parse_done   = parseDone_q;
  assign bus.runt_pkt     = runt_q;
  assign bus.hdr_overflow = overflow_q;

endmodule

// File: tb/tb_as_hdr_parser.sv
// Directed bench for as_hdr_parser: drives packets on the bus and plays the LUT.
module tb_as_hdr_parser;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   ovfCount = 0;
  int   runtCount = 0;
  int   doneSnap;

  as_hdr_parser_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_IQ_BITS(3)) bus ();

  as_hdr_parser #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_IQ_BITS(3),
    .SRC_PORT_POS(16), .IO_QUEUE_STAGE_NUM(8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.parse_done === 1'b1)   doneCount++;
    if (bus.hdr_overflow === 1'b1) ovfCount++;
    if (bus.runt_pkt === 1'b1)     runtCount++;
  end

  // Hard time limit so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ctrl, input logic [63:0] data, input logic wr);
    @(negedge clk);
    bus.in_ctrl = ctrl;
    bus.in_data = data;
    bus.in_wr   = wr;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(8'h00, 64'h0, 1'b0);
  endtask

  function automatic logic [63:0] pktData(input int idx, input logic [2:0] port,
                                          input logic [47:0] dmac, input logic [47:0] smac,
                                          input logic [15:0] etype, input logic [31:0] sip,
                                          input logic [31:0] dip);
    logic [63:0] d;
    d = 64'h0;
    case (idx)
      0: d[18:16] = port;
      1: d = {dmac, smac[47:32]};
      2: d = {smac[31:0], etype, 16'h4500};
      3: d = 64'h0054_0000_4000_4011;
      4: d = {16'h0000, sip, dip[31:16]};
      5: d = {dip[15:0], 48'h0};
      default: d = 64'h0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] pktCtrl(input int idx, input int nWords);
    if (idx == 0) return 8'hFF;
    if (idx == nWords - 1) return 8'h80;
    return 8'h00;
  endfunction

  task automatic sendPacket(input logic [2:0] port, input logic [47:0] dmac, input logic [47:0] smac,
                            input logic [15:0] etype, input logic [31:0] sip, input logic [31:0] dip,
                            input int nWords);
    for (int i = 0; i < nWords; i++)
      applyStimulus(pktCtrl(i, nWords), pktData(i, port, dmac, smac, etype, sip, dip), 1'b1);
  endtask

  task automatic checkHead(input string tag, input logic [2:0] port, input logic [47:0] dmac,
                           input logic [47:0] smac, input logic isIp, input logic [31:0] sip,
                           input logic [31:0] dip);
    checkOutput({tag, "_src_port"}, 64'(bus.src_port), 64'(port));
    checkOutput({tag, "_dst_mac"},  64'(bus.dst_mac),  64'(dmac));
    checkOutput({tag, "_src_mac"},  64'(bus.src_mac),  64'(smac));
    checkOutput({tag, "_is_ip"},    64'(bus.is_ip),    64'(isIp));
    checkOutput({tag, "_src_ip"},   64'(bus.src_ip),   64'(sip));
    checkOutput({tag, "_dst_ip"},   64'(bus.dst_ip),   64'(dip));
  endtask

  task automatic waitReq(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (bus.lookup_req !== 1'b1 && n < maxCycles) begin
      idle(1);
      n++;
    end
    checkOutput({tag, "_req_seen"}, 64'(bus.lookup_req), 64'd1);
  endtask

  task automatic ackHead(input string tag);
    bus.lookup_ack = 1'b1;
    idle(1);
    checkOutput({tag, "_req_drop"}, 64'(bus.lookup_req), 64'd0);
    bus.lookup_ack = 1'b0;
    idle(1);
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_data    = 64'h0;
    bus.in_ctrl    = 8'h00;
    bus.in_wr      = 1'b0;
    bus.lookup_ack = 1'b0;

    // Reset state
    idle(3);
    checkOutput("rst_req",      64'(bus.lookup_req),   64'd0);
    checkOutput("rst_done",     64'(bus.parse_done),   64'd0);
    checkOutput("rst_runt",     64'(bus.runt_pkt),     64'd0);
    checkOutput("rst_ovf",      64'(bus.hdr_overflow), 64'd0);
    checkHead("rst", 3'd0, 48'h0, 48'h0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    idle(2);

    // Single IPv4 packet, hand-built words
    $display("[TB] single IPv4 packet");
    applyStimulus(8'hFF, 64'h0000_0000_0002_0000, 1'b1);
    applyStimulus(8'h00, 64'h0011_2233_4455_6677, 1'b1);
    applyStimulus(8'h00, 64'h8899_AABB_0800_4500, 1'b1);
    applyStimulus(8'h00, 64'h0054_0000_4000_4006, 1'b1);
    applyStimulus(8'h00, 64'h0000_0A00_0001_0A00, 1'b1);
    applyStimulus(8'h80, 64'h0002_0000_0000_0000, 1'b1);
    idle(1);
    checkOutput("ip_done_pulse", 64'(bus.parse_done), 64'd1);
    checkOutput("ip_req_early",  64'(bus.lookup_req), 64'd0);
    idle(1);
    checkOutput("ip_req_lat",    64'(bus.lookup_req), 64'd1);
    checkOutput("ip_done_clear", 64'(bus.parse_done), 64'd0);
    checkHead("ip", 3'd2, 48'h0011_2233_4455, 48'h6677_8899_AABB, 1'b1, 32'h0A00_0001, 32'h0A00_0002);
    idle(1);
    checkOutput("ip_req_hold",   64'(bus.lookup_req), 64'd1);
    ackHead("ip");
    checkOutput("ip_done_count", 64'(doneCount), 64'd1);

    // Non-IP packet with an extra module header, 8 words
    $display("[TB] non-IP packet");
    applyStimulus(8'hFF, pktData(0, 3'd5, 48'hAABB_CCDD_EEFF, 48'h0102_0304_0506, 16'h0806, 32'hC0A8_0101, 32'hC0A8_0202), 1'b1);
    applyStimulus(8'h40, 64'hDEAD_BEEF_0000_0007, 1'b1);
    for (int i = 1; i < 8; i++)
      applyStimulus(pktCtrl(i, 8),
                    pktData(i, 3'd5, 48'hAABB_CCDD_EEFF, 48'h0102_0304_0506, 16'h0806, 32'hC0A8_0101, 32'hC0A8_0202),
                    1'b1);
    waitReq("arp", 10);
    checkHead("arp", 3'd5, 48'hAABB_CCDD_EEFF, 48'h0102_0304_0506, 1'b0, 32'h0, 32'h0);
    ackHead("arp");
    checkOutput("arp_done_count", 64'(doneCount), 64'd2);

    // Three back-to-back packets, ack held low: third overflows
    $display("[TB] FIFO overflow");
    sendPacket(3'd1, 48'h0A0A_0A0A_0A01, 48'h0B0B_0B0B_0B01, 16'h0800, 32'h0101_0101, 32'h0202_0201, 6);
    sendPacket(3'd3, 48'h0A0A_0A0A_0A02, 48'h0B0B_0B0B_0B02, 16'h0800, 32'h0101_0102, 32'h0202_0202, 6);
    sendPacket(3'd6, 48'h0A0A_0A0A_0A03, 48'h0B0B_0B0B_0B03, 16'h0800, 32'h0101_0103, 32'h0202_0203, 6);
    idle(1);
    checkOutput("ovf_pulse", 64'(bus.hdr_overflow), 64'd1);
    idle(1);
    checkOutput("ovf_clear", 64'(bus.hdr_overflow), 64'd0);
    checkOutput("ovf_req_a", 64'(bus.lookup_req), 64'd1);
    checkHead("ovf_a", 3'd1, 48'h0A0A_0A0A_0A01, 48'h0B0B_0B0B_0B01, 1'b1, 32'h0101_0101, 32'h0202_0201);
    ackHead("ovf_a");
    waitReq("ovf_b", 10);
    checkHead("ovf_b", 3'd3, 48'h0A0A_0A0A_0A02, 48'h0B0B_0B0B_0B02, 1'b1, 32'h0101_0102, 32'h0202_0202);
    ackHead("ovf_b");
    idle(4);
    checkOutput("ovf_no_third", 64'(bus.lookup_req), 64'd0);
    checkOutput("ovf_count",    64'(ovfCount),       64'd1);
    checkOutput("ovf_done_cnt", 64'(doneCount),      64'd4);

    // Runt packet (EOP on word 3), then a good packet
    $display("[TB] runt packet");
    sendPacket(3'd4, 48'h1111_1111_1111, 48'h2222_2222_2222, 16'h0800, 32'h0303_0303, 32'h0404_0404, 4);
    idle(1);
    checkOutput("runt_pulse", 64'(bus.runt_pkt), 64'd1);
    idle(1);
    checkOutput("runt_clear", 64'(bus.runt_pkt), 64'd0);
    idle(3);
    checkOutput("runt_no_req", 64'(bus.lookup_req), 64'd0);
    sendPacket(3'd7, 48'h3333_4444_5555, 48'h6666_7777_8888, 16'h0800, 32'hAC10_0001, 32'hAC10_0002, 7);
    waitReq("runt_next", 10);
    checkHead("runt_next", 3'd7, 48'h3333_4444_5555, 48'h6666_7777_8888, 1'b1, 32'hAC10_0001, 32'hAC10_0002);
    ackHead("runt_next");
    checkOutput("runt_count", 64'(runtCount), 64'd1);

    // Ack held high after req drop delays the next request
    $display("[TB] stale ack");
    sendPacket(3'd0, 48'hD0D0_D0D0_D0D0, 48'hD1D1_D1D1_D1D1, 16'h0800, 32'h0505_0505, 32'h0606_0606, 6);
    sendPacket(3'd6, 48'hE0E0_E0E0_E0E0, 48'hE1E1_E1E1_E1E1, 16'h86DD, 32'h0707_0707, 32'h0808_0808, 6);
    waitReq("stale_d", 10);
    checkHead("stale_d", 3'd0, 48'hD0D0_D0D0_D0D0, 48'hD1D1_D1D1_D1D1, 1'b1, 32'h0505_0505, 32'h0606_0606);
    bus.lookup_ack = 1'b1;
    idle(1);
    checkOutput("stale_drop", 64'(bus.lookup_req), 64'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checkOutput("stale_hold_low", 64'(bus.lookup_req), 64'd0);
    end
    bus.lookup_ack = 1'b0;
    idle(1);
    checkOutput("stale_after_fall", 64'(bus.lookup_req), 64'd0);
    idle(1);
    checkOutput("stale_next_req", 64'(bus.lookup_req), 64'd1);
    checkHead("stale_e", 3'd6, 48'hE0E0_E0E0_E0E0, 48'hE1E1_E1E1_E1E1, 1'b0, 32'h0, 32'h0);
    ackHead("stale_e");

    // Reset during DW3, bus keeps going
    $display("[TB] mid-packet reset");
    doneSnap = doneCount;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(pktCtrl(i, 7),
                    pktData(i, 3'd3, 48'hF0F0_F0F0_F0F0, 48'hF1F1_F1F1_F1F1, 16'h0800, 32'h0909_0909, 32'h0A0A_0A0A),
                    1'b1);
      if (i == 3) reset = 1'b1;
      if (i == 4) reset = 1'b0;
    end
    idle(5);
    checkOutput("mrst_no_req",  64'(bus.lookup_req), 64'd0);
    checkOutput("mrst_no_done", 64'(doneCount),      64'(doneSnap));
    checkOutput("mrst_head_zero", 64'(bus.dst_mac),  64'd0);
    sendPacket(3'd5, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 16'h0800, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 6);
    waitReq("mrst_next", 10);
    checkHead("mrst_next", 3'd5, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 1'b1, 32'h0B0B_0B0B, 32'h0C0C_0C0C);
    ackHead("mrst_next");
    idle(2);
    checkOutput("final_done_count", 64'(doneCount), 64'd8);
    checkOutput("final_ovf_count",  64'(ovfCount),  64'd1);
    checkOutput("final_runt_count", 64'(runtCount), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
